// File: rtl/ps2_lynx_matrix_if.sv
// PS/2 line, CPU row select and keyboard result bundle.
// master: host side driving PS/2 lines and row; slave: the matrix block.
interface ps2_lynx_matrix_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] row_i;
  logic [7:0] keys_o;
  logic [7:0] code_o;
  logic       code_vld_o;
  logic       err_o;

  modport master (
    output ps2_clk, ps2_data, row_i,
    input  keys_o, code_o, code_vld_o, err_o
  );

  modport slave (
    input  ps2_clk, ps2_data, row_i,
    output keys_o, code_o, code_vld_o, err_o
  );
endinterface

// File: rtl/ps2_lynx_matrix.sv
// PS/2 keyboard receiver feeding a Lynx 10x8 key matrix.
// Ports: clock, reset_n, bus (slave: ps2 lines, row_i -> keys/code/strobes).
module ps2_lynx_matrix #(
  parameter logic [15:0] TIMEOUT = 16'd50000,
  parameter int          ROWS    = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  ps2_lynx_matrix_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } st_t;

  localparam logic [4:0] ROWS_W = 5'(ROWS);

  logic [2:0]  c_sync;
  logic [1:0]  d_sync;
  logic        fall;
  logic        d;

  st_t         st, st_n;
  logic [7:0]  shift, shift_n;
  logic [2:0]  bitc, bit_n;
  logic        perr, perr_n;
  logic [15:0] cnt, cnt_n;
  logic        deliver, err_n;

  logic [7:0]  code_q;
  logic        vld_q;
  logic        err_q;
  logic [7:0]  keys_q;

  logic        ext, rel;
  logic [2:0]  skip;
  logic [7:0]  km;
  logic [7:0]  matrix [ROWS];

  // {ext, code} -> {valid, row[3:0], col[2:0]}
  function automatic logic [7:0] keymap(
    input logic [8:0] k
  );
    logic [7:0] r;
    r = 8'h00;
    case (k)
      9'h012: r = {1'b1, 4'd0, 3'd0};
      9'h059: r = {1'b1, 4'd0, 3'd0};
      9'h076: r = {1'b1, 4'd0, 3'd1};
      9'h172: r = {1'b1, 4'd0, 3'd2};
      9'h175: r = {1'b1, 4'd0, 3'd3};
      9'h058: r = {1'b1, 4'd0, 3'd4};
      9'h016: r = {1'b1, 4'd0, 3'd5};
      9'h026: r = {1'b1, 4'd1, 3'd0};
      9'h025: r = {1'b1, 4'd1, 3'd1};
      9'h024: r = {1'b1, 4'd1, 3'd2};
      9'h022: r = {1'b1, 4'd1, 3'd3};
      9'h023: r = {1'b1, 4'd1, 3'd4};
      9'h021: r = {1'b1, 4'd1, 3'd5};
      9'h01E: r = {1'b1, 4'd2, 3'd0};
      9'h01C: r = {1'b1, 4'd2, 3'd1};
      9'h01D: r = {1'b1, 4'd2, 3'd2};
      9'h015: r = {1'b1, 4'd2, 3'd3};
      9'h01B: r = {1'b1, 4'd2, 3'd4};
      9'h01A: r = {1'b1, 4'd2, 3'd5};
      9'h02E: r = {1'b1, 4'd3, 3'd0};
      9'h02C: r = {1'b1, 4'd3, 3'd1};
      9'h02D: r = {1'b1, 4'd3, 3'd2};
      9'h02B: r = {1'b1, 4'd3, 3'd3};
      9'h034: r = {1'b1, 4'd3, 3'd4};
      9'h02A: r = {1'b1, 4'd3, 3'd5};
      9'h036: r = {1'b1, 4'd4, 3'd0};
      9'h035: r = {1'b1, 4'd4, 3'd1};
      9'h033: r = {1'b1, 4'd4, 3'd2};
      9'h032: r = {1'b1, 4'd4, 3'd3};
      9'h031: r = {1'b1, 4'd4, 3'd4};
      9'h03D: r = {1'b1, 4'd5, 3'd0};
      9'h03E: r = {1'b1, 4'd5, 3'd1};
      9'h03C: r = {1'b1, 4'd5, 3'd2};
      9'h03B: r = {1'b1, 4'd5, 3'd3};
      9'h03A: r = {1'b1, 4'd5, 3'd4};
      9'h046: r = {1'b1, 4'd6, 3'd0};
      9'h043: r = {1'b1, 4'd6, 3'd1};
      9'h044: r = {1'b1, 4'd6, 3'd2};
      9'h042: r = {1'b1, 4'd6, 3'd3};
      9'h041: r = {1'b1, 4'd6, 3'd4};
      9'h045: r = {1'b1, 4'd7, 3'd0};
      9'h04D: r = {1'b1, 4'd7, 3'd1};
      9'h04B: r = {1'b1, 4'd7, 3'd2};
      9'h049: r = {1'b1, 4'd7, 3'd3};
      9'h04C: r = {1'b1, 4'd7, 3'd4};
      9'h029: r = {1'b1, 4'd8, 3'd0};
      9'h04E: r = {1'b1, 4'd8, 3'd1};
      9'h054: r = {1'b1, 4'd8, 3'd2};
      9'h052: r = {1'b1, 4'd8, 3'd3};
      9'h04A: r = {1'b1, 4'd8, 3'd4};
      9'h066: r = {1'b1, 4'd9, 3'd0};
      9'h05B: r = {1'b1, 4'd9, 3'd1};
      9'h055: r = {1'b1, 4'd9, 3'd2};
      9'h05A: r = {1'b1, 4'd9, 3'd3};
      9'h16B: r = {1'b1, 4'd9, 3'd4};
      9'h174: r = {1'b1, 4'd9, 3'd5};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign fall = c_sync[2] & ~c_sync[1];
  assign d    = d_sync[1];
  assign km   = keymap({ext, code_q});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      c_sync <= 3'b111;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[1:0], bus.ps2_clk};
      d_sync <= {d_sync[0], bus.ps2_data};
    end
  end

  always_comb begin
    st_n    = st;
    shift_n = shift;
    bit_n   = bitc;
    perr_n  = perr;
    cnt_n   = 16'd0;
    deliver = 1'b0;
    err_n   = 1'b0;
    if (st != IDLE && !fall) cnt_n = cnt + 16'd1;
    unique case (st)
      IDLE: if (fall) begin
        if (!d) begin
          st_n   = DATA;
          bit_n  = 3'd0;
          perr_n = 1'b0;
        end else begin
          err_n = 1'b1;
        end
      end
      DATA: if (fall) begin
        shift_n = {d, shift[7:1]};
        bit_n   = bitc + 3'd1;
        if (bitc == 3'd7) st_n = PARITY;
      end
      PARITY: if (fall) begin
        // odd parity: data plus parity must hold an odd count of ones
        perr_n = ~(^{shift, d});
        st_n   = STOP;
      end
      STOP: if (fall) begin
        if (d && !perr) deliver = 1'b1;
        else            err_n   = 1'b1;
        st_n = IDLE;
      end
    endcase
    if (st != IDLE && !fall && cnt == TIMEOUT - 16'd1) begin
      st_n  = IDLE;
      err_n = 1'b1;
      cnt_n = 16'd0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st     <= IDLE;
      shift  <= 8'h00;
      bitc   <= 3'd0;
      perr   <= 1'b0;
      cnt    <= 16'd0;
      code_q <= 8'h00;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st     <= st_n;
      shift  <= shift_n;
      bitc   <= bit_n;
      perr   <= perr_n;
      cnt    <= cnt_n;
      vld_q  <= deliver;
      err_q  <= err_n;
      if (deliver) code_q <= shift;
    end
  end

  // E1 swallows the rest of the Pause sequence
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ext  <= 1'b0;
      rel  <= 1'b0;
      skip <= 3'd0;
      for (int r = 0; r < ROWS; r++) matrix[r] <= 8'h00;
    end else if (vld_q) begin
      if (skip != 3'd0) begin
        skip <= skip - 3'd1;
      end else if (code_q == 8'hE1) begin
        skip <= 3'd7;
      end else if (code_q == 8'hE0) begin
        ext <= 1'b1;
      end else if (code_q == 8'hF0) begin
        rel <= 1'b1;
      end else begin
        if (km[7] && {1'b0, km[6:3]} < ROWS_W)
          matrix[km[6:3]][km[2:0]] <= ~rel;
        ext <= 1'b0;
        rel <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) keys_q <= 8'hFF;
    else if ({1'b0, bus.row_i} < ROWS_W)
      keys_q <= ~matrix[bus.row_i];
    else
      keys_q <= 8'hFF;
  end

  assign bus.keys_o     = keys_q;
  assign bus.code_o     = code_q;
  assign bus.code_vld_o = vld_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_ps2_lynx_matrix.sv
// Directed bench for ps2_lynx_matrix.
// Drives PS/2 frames and checks matrix readout and strobes.
module tb_ps2_lynx_matrix;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  int   vld_cnt;
  int   err_cnt;

  ps2_lynx_matrix_if bus();

  ps2_lynx_matrix #(
    .TIMEOUT(16'd400),
    .ROWS   (10)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.code_vld_o === 1'b1) vld_cnt <= vld_cnt + 1;
    if (bus.err_o === 1'b1)      err_cnt <= err_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    wait_clk(5);
    bus.ps2_clk = 1'b0;
    wait_clk(10);
    bus.ps2_clk = 1'b1;
    wait_clk(5);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip);
    logic p;
    p = ~(^b) ^ flip;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(1'b1);
    wait_clk(8);
  endtask

  task automatic set_row(input logic [3:0] r);
    bus.row_i = r;
    wait_clk(3);
  endtask

  task automatic test_reset;
    checks++;
    if (bus.keys_o !== 8'hFF) begin
      errors++;
      $display("FAIL reset_keys got=%h want=FF", bus.keys_o);
    end
    checks++;
    if (bus.code_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_code got=%h want=00", bus.code_o);
    end
    checks++;
    if (bus.code_vld_o !== 1'b0 || bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes got=%b%b want=00",
               bus.code_vld_o, bus.err_o);
    end
  endtask

  task automatic test_make_break_a;
    int v0, e0;
    set_row(4'd2);
    v0 = vld_cnt;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0);
    checks++;
    if (vld_cnt - v0 !== 1 || bus.code_o !== 8'h1C) begin
      errors++;
      $display("FAIL make_a_code vld=%0d code=%h want 1/1C",
               vld_cnt - v0, bus.code_o);
    end
    checks++;
    if (bus.keys_o !== 8'hFD) begin
      errors++;
      $display("FAIL make_a_keys got=%h want=FD", bus.keys_o);
    end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    checks++;
    if (bus.keys_o !== 8'hFF || err_cnt !== e0) begin
      errors++;
      $display("FAIL break_a keys=%h err=%0d want FF/0",
               bus.keys_o, err_cnt - e0);
    end
  endtask

  task automatic test_ext_up;
    set_row(4'd0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    checks++;
    if (bus.keys_o !== 8'hF7) begin
      errors++;
      $display("FAIL ext_up_make got=%h want=F7", bus.keys_o);
    end
    send_frame(8'h75, 1'b0);
    checks++;
    if (bus.keys_o !== 8'hF7) begin
      errors++;
      $display("FAIL bare_75 got=%h want=F7", bus.keys_o);
    end
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    checks++;
    if (bus.keys_o !== 8'hFF) begin
      errors++;
      $display("FAIL ext_up_break got=%h want=FF", bus.keys_o);
    end
  endtask

  task automatic test_shift_shared;
    set_row(4'd0);
    send_frame(8'h12, 1'b0);
    checks++;
    if (bus.keys_o !== 8'hFE) begin
      errors++;
      $display("FAIL lshift_make got=%h want=FE", bus.keys_o);
    end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h59, 1'b0);
    checks++;
    if (bus.keys_o !== 8'hFF) begin
      errors++;
      $display("FAIL rshift_break got=%h want=FF", bus.keys_o);
    end
  endtask

  task automatic test_parity;
    int v0, e0;
    set_row(4'd2);
    v0 = vld_cnt;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1);
    checks++;
    if (err_cnt - e0 !== 1 || vld_cnt !== v0) begin
      errors++;
      $display("FAIL parity_err err=%0d vld=%0d want 1/0",
               err_cnt - e0, vld_cnt - v0);
    end
    checks++;
    if (bus.keys_o !== 8'hFF) begin
      errors++;
      $display("FAIL parity_keys got=%h want=FF", bus.keys_o);
    end
  endtask

  task automatic test_timeout;
    int v0, e0;
    v0 = vld_cnt;
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    wait_clk(450);
    checks++;
    if (err_cnt - e0 !== 1 || vld_cnt !== v0) begin
      errors++;
      $display("FAIL timeout_err err=%0d vld=%0d want 1/0",
               err_cnt - e0, vld_cnt - v0);
    end
    set_row(4'd8);
    send_frame(8'h29, 1'b0);
    checks++;
    if (bus.keys_o !== 8'hFE || bus.code_o !== 8'h29) begin
      errors++;
      $display("FAIL timeout_space keys=%h code=%h want FE/29",
               bus.keys_o, bus.code_o);
    end
  endtask

  task automatic test_pause;
    logic [7:0] seq [9];
    int v0;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0,
            8'h14, 8'hF0, 8'h77, 8'h1C};
    v0 = vld_cnt;
    for (int i = 0; i < 9; i++) send_frame(seq[i], 1'b0);
    checks++;
    if (vld_cnt - v0 !== 9) begin
      errors++;
      $display("FAIL pause_vld got=%0d want=9", vld_cnt - v0);
    end
    set_row(4'd2);
    checks++;
    if (bus.keys_o !== 8'hFD) begin
      errors++;
      $display("FAIL pause_a got=%h want=FD", bus.keys_o);
    end
    set_row(4'd0);
    checks++;
    if (bus.keys_o !== 8'hFF) begin
      errors++;
      $display("FAIL pause_row0 got=%h want=FF", bus.keys_o);
    end
  endtask

  task automatic test_rows_and_reset;
    int v0;
    send_frame(8'h76, 1'b0);
    set_row(4'd0);
    checks++;
    if (bus.keys_o !== 8'hFD) begin
      errors++;
      $display("FAIL esc_row0 got=%h want=FD", bus.keys_o);
    end
    set_row(4'd12);
    checks++;
    if (bus.keys_o !== 8'hFF) begin
      errors++;
      $display("FAIL row12 got=%h want=FF", bus.keys_o);
    end
    send_frame(8'hE0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_n = 1'b0;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(3);
    for (int r = 0; r < 16; r++) begin
      set_row(4'(r));
      checks++;
      if (bus.keys_o !== 8'hFF) begin
        errors++;
        $display("FAIL rst_row%0d got=%h want=FF", r, bus.keys_o);
      end
    end
    set_row(4'd0);
    v0 = vld_cnt;
    send_frame(8'h75, 1'b0);
    checks++;
    if (vld_cnt - v0 !== 1 || bus.keys_o !== 8'hFF) begin
      errors++;
      $display("FAIL rst_idle vld=%0d keys=%h want 1/FF",
               vld_cnt - v0, bus.keys_o);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    vld_cnt     = 0;
    err_cnt     = 0;
    reset_n     = 1'b0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.row_i    = 4'd0;
    wait_clk(4);
    test_reset;
    reset_n = 1'b1;
    wait_clk(4);
    test_make_break_a;
    test_ext_up;
    test_shift_shared;
    test_parity;
    test_timeout;
    test_pause;
    test_rows_and_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
